data_mem_responder: RTL and testbench



---
 rtl/data_mem_responder.sv | 109 ++++++++++
 tb/tb_data_mem_responder.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Responder end of the MEM-stage data-memory interface.
// Services one read or write at a time from an internal word array with a
// fixed number of wait states, holding ready low so the pipeline freezes
// until the access completes.

module data_mem_responder #(
    parameter int WAIT_CYCLES = 4,
    parameter int DEPTH       = 64,
    parameter int BASE_ADDR   = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    input  logic [31:0] ALU_result,
    input  logic [31:0] ST_val,
    output logic [31:0] read_data,
    output logic        ready,
    output logic        addr_err
);

    // cnt only ever counts 0 .. WAIT_CYCLES-1 while BUSY
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] cnt;

    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic             write_q;

    logic [31:0]      mem [0:DEPTH-1];

    logic             req;
    logic [31:0]      offset;
    logic             in_range;
    logic [IDX_W-1:0] word_idx;
    logic             last_busy;

    assign req = MEM_R_EN | MEM_W_EN;

    // Range check on the latched address; an address below BASE_ADDR wraps
    // to a huge unsigned offset and therefore also fails the compare.
    assign offset   = addr_q - 32'(BASE_ADDR);
    assign in_range = offset < 32'(4 * DEPTH);
    assign word_idx = offset[IDX_W+1:2];

    assign last_busy = (state == BUSY) && (cnt == CNT_W'(WAIT_CYCLES - 1));

    assign ready = ((state == IDLE) && !req) || (state == DONE);

    // Next-state logic: IDLE waits for a request, BUSY runs the wait states,
    // DONE is a single completion cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req) state_nxt = BUSY;
            BUSY:    if (last_busy) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control state, request latch and registered results
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            write_q   <= 1'b0;
            read_data <= '0;
            addr_err  <= 1'b0;
        end else begin
            state <= state_nxt;

            if ((state == IDLE) && req) begin
                addr_q  <= ALU_result;
                wdata_q <= ST_val;
                write_q <= MEM_W_EN;
                cnt     <= '0;
            end else if (state == BUSY) begin
                cnt <= cnt + 1'b1;
            end

            if (last_busy) begin
                addr_err  <= !in_range;
                read_data <= (write_q || !in_range) ? 32'd0 : mem[word_idx];
            end else begin
                addr_err  <= 1'b0;
            end
        end
    end

    // Array write on the final BUSY edge; reset pulls state out of BUSY,
    // so an interrupted write never reaches this commit and is lost
    always_ff @(posedge clk) begin
        if (last_busy && write_q && in_range) begin
            mem[word_idx] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: each access pushes its expected
// DONE-cycle result, which is popped and compared when ready rises.

module tb_data_mem_responder;

    logic        clk;
    logic        rst;
    logic        MEM_R_EN;
    logic        MEM_W_EN;
    logic [31:0] ALU_result;
    logic [31:0] ST_val;
    logic [31:0] read_data;
    logic        ready;
    logic        addr_err;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] model_mem [0:63];
    logic [31:0] last_rd;
    int          checks;
    int          errors;

    data_mem_responder #(
        .WAIT_CYCLES(4),
        .DEPTH(64),
        .BASE_ADDR(1024)
    ) dut (
        .clk(clk),
        .rst(rst),
        .MEM_R_EN(MEM_R_EN),
        .MEM_W_EN(MEM_W_EN),
        .ALU_result(ALU_result),
        .ST_val(ST_val),
        .read_data(read_data),
        .ready(ready),
        .addr_err(addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // One full access: drive the request, push the model's expectation,
    // count ready-low cycles, then pop and compare in the DONE cycle.
    // drop_w_at >= 0 clears MEM_W_EN in that cycle of the access (0 = IDLE).
    task automatic apply_stimulus(input logic r, input logic w, input logic [31:0] addr,
                                  input logic [31:0] data, input int drop_w_at, input string tag);
        exp_t        e;
        exp_t        got;
        logic [31:0] off;
        logic        inr;
        logic [5:0]  idx;
        int          lows;

        @(negedge clk);
        MEM_R_EN   = r;
        MEM_W_EN   = w;
        ALU_result = addr;
        ST_val     = data;

        off = addr - 32'd1024;
        inr = off < 32'd256;
        idx = off[7:2];
        e.err  = !inr;
        e.data = (w || !inr) ? 32'd0 : model_mem[idx];
        if (w && inr) model_mem[idx] = data;
        sb_q.push_back(e);

        #1;
        lows = 0;
        while (!ready && lows < 20) begin
            if (lows == drop_w_at) MEM_W_EN = 1'b0;
            lows++;
            @(negedge clk);
            #1;
        end
        check_output({tag, "_lowcycles"}, 32'(lows), 32'd5);
        check_output({tag, "_ready_done"}, 32'(ready), 32'd1);

        got = sb_q.pop_front();
        check_output({tag, "_rdata"}, read_data, got.data);
        check_output({tag, "_err"}, 32'(addr_err), 32'(got.err));
        last_rd = got.data;

        MEM_R_EN = 1'b0;
        MEM_W_EN = 1'b0;
        @(negedge clk);
        #1;
        check_output({tag, "_err_after"}, 32'(addr_err), 32'd0);
        check_output({tag, "_rdata_hold"}, read_data, last_rd);
        check_output({tag, "_ready_idle"}, 32'(ready), 32'd1);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b0;
        MEM_R_EN   = 1'b0;
        MEM_W_EN   = 1'b0;
        ALU_result = '0;
        ST_val     = '0;
        last_rd    = '0;
        for (int i = 0; i < 64; i++) model_mem[i] = '0;

        repeat (3) @(negedge clk);
        #1;
        check_output("rst_ready", 32'(ready), 32'd1);
        check_output("rst_rdata", read_data, 32'd0);
        check_output("rst_err", 32'(addr_err), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Known contents for words 0..7 so later reads are deterministic
        for (int i = 0; i < 8; i++)
            apply_stimulus(1'b0, 1'b1, 32'd1024 + 32'(4 * i), 32'h1000_0000 + 32'(i), -1, "init_wr");

        apply_stimulus(1'b0, 1'b1, 32'd1028, 32'hDEAD_BEEF, -1, "wr1028");
        apply_stimulus(1'b1, 1'b0, 32'd1028, 32'h0, -1, "rd1028");
        apply_stimulus(1'b1, 1'b0, 32'd1030, 32'h0, -1, "rd1030");
        apply_stimulus(1'b1, 1'b0, 32'd1020, 32'h0, -1, "rd_low_oor");
        apply_stimulus(1'b0, 1'b1, 32'd1280, 32'hFFFF_0000, -1, "wr_high_oor");
        apply_stimulus(1'b1, 1'b0, 32'd1276, 32'h0, -1, "rd_last_word");
        apply_stimulus(1'b1, 1'b1, 32'd1032, 32'h1234_5678, -1, "both_en");
        apply_stimulus(1'b0, 1'b1, 32'd1036, 32'hA5A5_A5A5, 2, "wr_drop");
        apply_stimulus(1'b1, 1'b0, 32'd1028, 32'h0, -1, "rd_before_rst");

        // Reset during the 3rd BUSY cycle of a write to word 4
        @(negedge clk);
        MEM_W_EN   = 1'b1;
        ALU_result = 32'd1040;
        ST_val     = 32'h0000_0055;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check_output("busy3_ready", 32'(ready), 32'd0);
        check_output("busy3_rdata", read_data, 32'hDEAD_BEEF);
        rst = 1'b0;
        #1;
        check_output("abort_ready_req", 32'(ready), 32'd0);
        check_output("abort_rdata", read_data, 32'd0);
        check_output("abort_err", 32'(addr_err), 32'd0);
        MEM_W_EN = 1'b0;
        #1;
        check_output("abort_ready_idle", 32'(ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check_output("post_rst_ready", 32'(ready), 32'd1);

        apply_stimulus(1'b1, 1'b0, 32'd1040, 32'h0, -1, "rd_word4");
        apply_stimulus(1'b1, 1'b0, 32'd1028, 32'h0, -1, "rd1028_again");

        // Sweep words 0..7 to confirm nothing else was disturbed
        for (int i = 0; i < 8; i++)
            apply_stimulus(1'b1, 1'b0, 32'd1024 + 32'(4 * i), 32'h0, -1, "sweep");

        check_output("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
